peg_move_ctrl: RTL and testbench

Player input front-end for the peg solitaire board. Five raw push-buttons are synchronised and debounced, and turned into single press events. A navigate/select/fire state machine walks a cursor over the 7x7 grid and, when the player commits a move, presents `piece_x`/`piece_y`/`direction` to the board stage for exactly one cycle. It sits directly upstream of the board. In every other cycle it drives the out-of-grid coordinate (7,7), so the board sees no move request.

---
 rtl/peg_move_ctrl.sv | 266 ++++++++++++++++++++++++++
 tb/tb_peg_move_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/peg_move_ctrl.sv
// ---------------------------------------------------------------------------
// peg_move_ctrl
//
// Player input front-end for the peg solitaire board. Five raw push-buttons
// are synchronised, debounced and turned into single-cycle press events. A
// navigate/select/fire state machine walks a cursor over the 7x7 grid. When
// the player commits a move, piece_x/piece_y/direction are presented to the
// board for exactly one cycle. In every other cycle the out-of-grid
// coordinate (7,7) is driven, so the board sees no move request.
//
// Parameters:
//   DEBOUNCE_CYCLES : consecutive synchronised samples at the new level that
//                     are needed to accept a button change (>= 1)
//
// Ports:
//   clk          in  1 : clock, all state updates on the rising edge
//   rst          in  1 : synchronous active-high reset
//   btn_left     in  1 : raw asynchronous button, active high
//   btn_right    in  1 : raw asynchronous button, active high
//   btn_up       in  1 : raw asynchronous button, active high
//   btn_down     in  1 : raw asynchronous button, active high
//   btn_sel      in  1 : raw asynchronous button, active high
//   game_over    in  1 : from the board, high when no legal move remains
//   piece_x      out 3 : origin column of the move, 7 when idle
//   piece_y      out 3 : origin row of the move, 7 when idle
//   direction    out 2 : LEFT=00, RIGHT=01, UP=10, DOWN=11 (held until the
//                        next move is latched)
//   move_strobe  out 1 : high in the single cycle the move is presented
//   cursor_x     out 3 : cursor column, for display
//   cursor_y     out 3 : cursor row, for display
//   selected     out 1 : high while the FSM is in SELECTED
//
// Handshake: the move interface is a valid-only strobe. move_strobe acts as
// valid and qualifies piece_x/piece_y/direction for that one cycle; there is
// no ready, the board must take or ignore the move in that cycle.
//
// All outputs come straight from flops; there is no combinational path from
// any input to any output.
// ---------------------------------------------------------------------------
module peg_move_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_sel,
  input  logic       game_over,
  output logic [2:0] piece_x,
  output logic [2:0] piece_y,
  output logic [1:0] direction,
  output logic       move_strobe,
  output logic [2:0] cursor_x,
  output logic [2:0] cursor_y,
  output logic       selected
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  // Button bit order, also the arbitration priority (bit 0 wins).
  localparam int B_SEL   = 0;
  localparam int B_LEFT  = 1;
  localparam int B_RIGHT = 2;
  localparam int B_UP    = 3;
  localparam int B_DOWN  = 4;

  localparam logic [1:0] DIR_LEFT  = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_UP    = 2'b10;
  localparam logic [1:0] DIR_DOWN  = 2'b11;

  localparam logic [2:0] COORD_IDLE = 3'd7;
  localparam logic [2:0] COORD_HOME = 3'd3;
  localparam logic [2:0] COORD_MAX  = 3'd6;

  typedef enum logic [1:0] {
    ST_NAVIGATE = 2'd0,
    ST_SELECTED = 2'd1,
    ST_FIRE     = 2'd2
  } state_e;

  // -------------------------------------------------------------------------
  // Input conditioning
  // -------------------------------------------------------------------------
  logic [4:0]         btn_raw;
  logic [4:0]         sync1_q;
  logic [4:0]         sync2_q;
  logic [4:0]         db_q;
  logic [4:0]         db_d;
  logic [4:0]         db_prev_q;
  logic [4:0][CW-1:0] cnt_q;
  logic [4:0][CW-1:0] cnt_d;
  logic [4:0]         press;

  assign btn_raw = {btn_down, btn_up, btn_right, btn_left, btn_sel};

  // The counter measures how long the synchronised level has disagreed with
  // the accepted level. Any return to agreement (a bounce) clears it, so only
  // an uninterrupted run of DEBOUNCE_CYCLES samples flips db.
  always_comb begin
    for (int i = 0; i < 5; i++) begin
      cnt_d[i] = cnt_q[i];
      db_d[i]  = db_q[i];
      if (sync2_q[i] == db_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        db_d[i]  = sync2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      db_q      <= '0;
      db_prev_q <= '0;
      cnt_q     <= '0;
    end else begin
      sync1_q   <= btn_raw;
      sync2_q   <= sync1_q;
      db_q      <= db_d;
      db_prev_q <= db_q;
      cnt_q     <= cnt_d;
    end
  end

  // Rising edge of the debounced level only; releases produce nothing.
  assign press = db_q & ~db_prev_q;

  // -------------------------------------------------------------------------
  // Event arbitration: one event per cycle, sel > left > right > up > down.
  // -------------------------------------------------------------------------
  logic       ev_sel;
  logic       ev_dir;
  logic [1:0] ev_dir_code;

  always_comb begin
    ev_sel      = press[B_SEL];
    ev_dir      = 1'b0;
    ev_dir_code = DIR_LEFT;
    if (!press[B_SEL]) begin
      if (press[B_LEFT]) begin
        ev_dir      = 1'b1;
        ev_dir_code = DIR_LEFT;
      end else if (press[B_RIGHT]) begin
        ev_dir      = 1'b1;
        ev_dir_code = DIR_RIGHT;
      end else if (press[B_UP]) begin
        ev_dir      = 1'b1;
        ev_dir_code = DIR_UP;
      end else if (press[B_DOWN]) begin
        ev_dir      = 1'b1;
        ev_dir_code = DIR_DOWN;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Cursor stepping with wrap-around on the 0..6 grid. Up decrements y.
  // -------------------------------------------------------------------------
  function automatic logic [2:0] step_dec(input logic [2:0] v);
    return (v == 3'd0) ? COORD_MAX : v - 3'd1;
  endfunction

  function automatic logic [2:0] step_inc(input logic [2:0] v);
    return (v >= COORD_MAX) ? 3'd0 : v + 3'd1;
  endfunction

  logic [2:0] cursor_x_q;
  logic [2:0] cursor_y_q;
  logic [2:0] cursor_x_d;
  logic [2:0] cursor_y_d;

  always_comb begin
    cursor_x_d = cursor_x_q;
    cursor_y_d = cursor_y_q;
    case (ev_dir_code)
      DIR_LEFT:  cursor_x_d = step_dec(cursor_x_q);
      DIR_RIGHT: cursor_x_d = step_inc(cursor_x_q);
      DIR_UP:    cursor_y_d = step_dec(cursor_y_q);
      default:   cursor_y_d = step_inc(cursor_y_q);
    endcase
  end

  // -------------------------------------------------------------------------
  // Navigate / select / fire FSM with registered outputs
  // -------------------------------------------------------------------------
  state_e     state_q;
  logic [2:0] piece_x_q;
  logic [2:0] piece_y_q;
  logic [1:0] direction_q;
  logic       move_strobe_q;
  logic       selected_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_NAVIGATE;
      cursor_x_q    <= COORD_HOME;
      cursor_y_q    <= COORD_HOME;
      piece_x_q     <= COORD_IDLE;
      piece_y_q     <= COORD_IDLE;
      direction_q   <= DIR_LEFT;
      move_strobe_q <= 1'b0;
      selected_q    <= 1'b0;
    end else begin
      // Move outputs idle unless this edge enters FIRE.
      piece_x_q     <= COORD_IDLE;
      piece_y_q     <= COORD_IDLE;
      move_strobe_q <= 1'b0;
      case (state_q)
        ST_NAVIGATE: begin
          if (!game_over) begin
            if (ev_sel) begin
              state_q    <= ST_SELECTED;
              selected_q <= 1'b1;
            end else if (ev_dir) begin
              cursor_x_q <= cursor_x_d;
              cursor_y_q <= cursor_y_d;
            end
          end
        end
        ST_SELECTED: begin
          // game_over is checked first so it beats a same-cycle fire.
          if (game_over || ev_sel) begin
            state_q    <= ST_NAVIGATE;
            selected_q <= 1'b0;
          end else if (ev_dir) begin
            state_q       <= ST_FIRE;
            selected_q    <= 1'b0;
            direction_q   <= ev_dir_code;
            piece_x_q     <= cursor_x_q;
            piece_y_q     <= cursor_y_q;
            move_strobe_q <= 1'b1;
          end
        end
        ST_FIRE: begin
          // Single presentation cycle; events here are dropped and a
          // game_over does not abort the move already on the outputs.
          state_q    <= ST_NAVIGATE;
          selected_q <= 1'b0;
        end
        default: begin
          state_q    <= ST_NAVIGATE;
          selected_q <= 1'b0;
        end
      endcase
    end
  end

  assign piece_x     = piece_x_q;
  assign piece_y     = piece_y_q;
  assign direction   = direction_q;
  assign move_strobe = move_strobe_q;
  assign cursor_x    = cursor_x_q;
  assign cursor_y    = cursor_y_q;
  assign selected    = selected_q;

endmodule

// File: tb/tb_peg_move_ctrl.sv
// ---------------------------------------------------------------------------
// tb_peg_move_ctrl
//
// Directed bench for peg_move_ctrl with DEBOUNCE_CYCLES=4. Expected values
// are hand-derived: a button raised just after an edge is first sampled at
// the next edge k, and the resulting cursor/FSM update is visible after edge
// k+6.
// ---------------------------------------------------------------------------
module tb_peg_move_ctrl;

  localparam int DB = 4;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       btn_left;
  logic       btn_right;
  logic       btn_up;
  logic       btn_down;
  logic       btn_sel;
  logic       game_over;
  logic [2:0] piece_x;
  logic [2:0] piece_y;
  logic [1:0] direction;
  logic       move_strobe;
  logic [2:0] cursor_x;
  logic [2:0] cursor_y;
  logic       selected;

  peg_move_ctrl #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .btn_sel    (btn_sel),
    .game_over  (game_over),
    .piece_x    (piece_x),
    .piece_y    (piece_y),
    .direction  (direction),
    .move_strobe(move_strobe),
    .cursor_x   (cursor_x),
    .cursor_y   (cursor_y),
    .selected   (selected)
  );

  int checks   = 0;
  int failures = 0;
  int strobe_cnt = 0;
  int s0;

  // Counts every strobe cycle so dropped or duplicated moves are visible.
  always @(posedge clk) if (move_strobe === 1'b1) strobe_cnt++;

  // Scoreboard check
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_btn(input int idx, input logic v);
    case (idx)
      0: btn_sel   = v;
      1: btn_left  = v;
      2: btn_right = v;
      3: btn_up    = v;
      default: btn_down = v;
    endcase
  endtask

  // Hold long enough for one accepted press, then release and let the
  // debounced level settle low again.
  task automatic press(input int idx);
    set_btn(idx, 1'b1);
    repeat (DB + 3) tick();
    set_btn(idx, 1'b0);
    repeat (DB + 4) tick();
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_strobe"}, {7'd0, move_strobe}, 8'd0);
    check({tag, "_px"}, {5'd0, piece_x}, 8'd7);
    check({tag, "_py"}, {5'd0, piece_y}, 8'd7);
  endtask

  int exp_left [5] = '{3, 2, 1, 0, 6};
  int exp_down [4] = '{4, 5, 6, 0};

  initial begin
    rst = 1'b1; btn_left = 0; btn_right = 0; btn_up = 0; btn_down = 0;
    btn_sel = 0; game_over = 0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_cx", {5'd0, cursor_x}, 8'd3);
    check("rst_cy", {5'd0, cursor_y}, 8'd3);
    check("rst_sel", {7'd0, selected}, 8'd0);
    check("rst_dir", {6'd0, direction}, 8'd0);
    check_idle("rst");

    // Bounce shorter than the debounce window
    btn_right = 1'b1;
    repeat (3) tick();
    btn_right = 1'b0;
    repeat (10) tick();
    check("glitch_cx", {5'd0, cursor_x}, 8'd3);

    // Held press: exact latency, single step
    btn_right = 1'b1;
    repeat (DB + 2) tick();
    check("lat_early_cx", {5'd0, cursor_x}, 8'd3);
    tick();
    check("lat_cx", {5'd0, cursor_x}, 8'd4);
    repeat (3) tick();
    btn_right = 1'b0;
    repeat (10) tick();
    check("one_step_cx", {5'd0, cursor_x}, 8'd4);

    // Wrap left 4 -> 3,2,1,0,6
    for (int i = 0; i < 5; i++) begin
      press(1);
      check($sformatf("wrap_left%0d", i), {5'd0, cursor_x}, exp_left[i][7:0]);
    end
    // Wrap down 3 -> 4,5,6,0
    for (int i = 0; i < 4; i++) begin
      press(4);
      check($sformatf("wrap_down%0d", i), {5'd0, cursor_y}, exp_down[i][7:0]);
    end

    // Reset back home, then down twice to (3,5)
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst2_cx", {5'd0, cursor_x}, 8'd3);
    check("rst2_cy", {5'd0, cursor_y}, 8'd3);
    press(4);
    press(4);
    check("pos_cy", {5'd0, cursor_y}, 8'd5);

    // Full move: sel, up
    s0 = strobe_cnt;
    press(0);
    check("fm_selected", {7'd0, selected}, 8'd1);
    check_idle("fm_wait");
    btn_up = 1'b1;
    repeat (DB + 2) tick();
    check("fm_pre_strobe", {7'd0, move_strobe}, 8'd0);
    tick();
    check("fm_strobe", {7'd0, move_strobe}, 8'd1);
    check("fm_px", {5'd0, piece_x}, 8'd3);
    check("fm_py", {5'd0, piece_y}, 8'd5);
    check("fm_dir", {6'd0, direction}, 8'd2);
    check("fm_sel_low", {7'd0, selected}, 8'd0);
    tick();
    check_idle("fm_after");
    check("fm_dir_hold", {6'd0, direction}, 8'd2);
    check("fm_cx", {5'd0, cursor_x}, 8'd3);
    check("fm_cy", {5'd0, cursor_y}, 8'd5);
    btn_up = 1'b0;
    repeat (DB + 4) tick();
    check("fm_one_strobe", 8'(strobe_cnt - s0), 8'd1);

    // Cancel: sel, sel
    s0 = strobe_cnt;
    press(0);
    check("cancel_sel1", {7'd0, selected}, 8'd1);
    press(0);
    check("cancel_sel2", {7'd0, selected}, 8'd0);
    check("cancel_nostrobe", 8'(strobe_cnt - s0), 8'd0);

    // sel and left in the same cycle: sel wins, cursor unchanged
    btn_sel = 1'b1;
    btn_left = 1'b1;
    repeat (DB + 3) tick();
    btn_sel = 1'b0;
    btn_left = 1'b0;
    repeat (DB + 4) tick();
    check("arb_selected", {7'd0, selected}, 8'd1);
    check("arb_cx", {5'd0, cursor_x}, 8'd3);
    press(0);
    check("arb_cancel", {7'd0, selected}, 8'd0);

    // game_over while SELECTED
    s0 = strobe_cnt;
    press(0);
    check("go_sel", {7'd0, selected}, 8'd1);
    game_over = 1'b1;
    tick();
    check("go_forced", {7'd0, selected}, 8'd0);
    press(4);
    check("go_ign_down", {5'd0, cursor_y}, 8'd5);
    press(0);
    check("go_ign_sel", {7'd0, selected}, 8'd0);
    check("go_nostrobe", 8'(strobe_cnt - s0), 8'd0);
    game_over = 1'b0;
    tick();
    press(4);
    check("go_release_cy", {5'd0, cursor_y}, 8'd6);

    // game_over rises in the cycle SELECTED would fire
    s0 = strobe_cnt;
    press(0);
    btn_up = 1'b1;
    repeat (DB + 2) tick();
    game_over = 1'b1;
    tick();
    check("race_strobe", {7'd0, move_strobe}, 8'd0);
    check("race_sel", {7'd0, selected}, 8'd0);
    btn_up = 1'b0;
    repeat (DB + 4) tick();
    game_over = 1'b0;
    tick();
    check("race_nostrobe", 8'(strobe_cnt - s0), 8'd0);

    // Reset in the FIRE cycle, then a button held across reset
    press(0);
    btn_up = 1'b1;
    repeat (DB + 3) tick();
    check("rf_strobe", {7'd0, move_strobe}, 8'd1);
    rst = 1'b1;
    btn_up = 1'b0;
    tick();
    check_idle("rf");
    check("rf_cy", {5'd0, cursor_y}, 8'd3);
    check("rf_dir", {6'd0, direction}, 8'd0);
    btn_right = 1'b1;
    tick();
    rst = 1'b0;
    repeat (DB + 2) tick();
    check("held_early_cx", {5'd0, cursor_x}, 8'd3);
    tick();
    check("held_cx", {5'd0, cursor_x}, 8'd4);
    btn_right = 1'b0;
    repeat (DB + 4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
